// File: rtl/rice_pkg.sv
// Shared definitions for the Rice residual decoder: default widths, FSM state
// encoding and the zigzag decode used by the output stage and bench models.
package rice_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int RP_W_DEF   = 4;

   typedef enum logic {
      S_UNARY = 1'b0,
      S_REM   = 1'b1
   } state_e;

   // Even codes map to u/2, odd codes to -(u+1)/2.
   function automatic logic signed [DATA_W_DEF-1:0] zigzag_decode(input logic [DATA_W_DEF-1:0] u);
      return signed'((u >> 1) ^ {DATA_W_DEF{u[0]}});
   endfunction

endpackage

// File: rtl/rice_zigzag_decode.sv
// Combinational zigzag decode of an unsigned Rice code into a signed residual.
module rice_zigzag_decode
   import rice_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic        [DATA_W-1:0] iCode,
   output logic signed [DATA_W-1:0] oResidual
);

   generate
      if (DATA_W == DATA_W_DEF) begin : g_pkg
         assign oResidual = zigzag_decode(iCode);
      end else begin : g_generic
         assign oResidual = signed'((iCode >> 1) ^ {DATA_W{iCode[0]}});
      end
   endgenerate

endmodule

// File: rtl/variable_rice_decoder.sv
// Serial Rice/FLAC residual decoder, one coded bit per accepted cycle.
// Optional `RICE_DEC_MSBLSB_EN exposes the decoded quotient/remainder fields.
module variable_rice_decoder
   import rice_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RP_W   = RP_W_DEF
) (
   input  logic                     iClock,
   input  logic                     iReset,
   input  logic                     iValid,
   input  logic                     iBit,
   output logic                     oReady,
   input  logic        [RP_W-1:0]   iRiceParam,
   output logic signed [DATA_W-1:0] oSample,
   output logic                     oValid,
   output logic                     oError
`ifdef RICE_DEC_MSBLSB_EN
   ,
   output logic        [DATA_W-1:0] oMSB,
   output logic        [DATA_W-1:0] oLSB
`endif
);

   state_e                     state_q;
   logic        [DATA_W-1:0]   q_q;
   logic        [DATA_W-1:0]   r_q;
   logic        [RP_W-1:0]     cnt_q;
   logic        [RP_W-1:0]     rp_q;
   logic                       first_q;
   logic                       err_q;
   logic                       valid_q;
   logic signed [DATA_W-1:0]   sample_q;
`ifdef RICE_DEC_MSBLSB_EN
   logic        [DATA_W-1:0]   msb_q;
   logic        [DATA_W-1:0]   lsb_q;
`endif

   logic                       accept;
   logic        [RP_W-1:0]     rp_eff;
   logic        [DATA_W-1:0]   q_limit;
   logic        [DATA_W-1:0]   r_next;
   logic        [DATA_W-1:0]   u_rem;
   logic        [DATA_W-1:0]   code_u;
   logic                       done_unary;
   logic                       done_rem;
   logic                       overflow;
   logic signed [DATA_W-1:0]   residual;

   assign accept  = iValid && !err_q;
   // The parameter is only taken from the port on a codeword's first bit.
   assign rp_eff  = first_q ? iRiceParam : rp_q;
   assign q_limit = {DATA_W{1'b1}} >> rp_eff;
   assign r_next  = DATA_W'({r_q, iBit});
   // Widened shift; the quotient limit keeps the discarded upper bits zero.
   assign u_rem   = DATA_W'((DATA_W+RP_W)'(q_q) << rp_eff) | r_next;
   assign code_u  = (state_q == S_REM) ? u_rem : q_q;

   assign done_unary = accept && (state_q == S_UNARY) && iBit && (rp_eff == '0);
   assign done_rem   = accept && (state_q == S_REM) && (cnt_q == RP_W'(1));
   assign overflow   = accept && (state_q == S_UNARY) && !iBit && (q_q == q_limit);

   rice_zigzag_decode #(.DATA_W(DATA_W)) u_zigzag (
      .iCode     (code_u),
      .oResidual (residual)
   );

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q  <= S_UNARY;
         q_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         rp_q     <= '0;
         first_q  <= 1'b1;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         sample_q <= '0;
`ifdef RICE_DEC_MSBLSB_EN
         msb_q    <= '0;
         lsb_q    <= '0;
`endif
      end else begin
         valid_q <= done_unary || done_rem;
         if (accept) begin
            first_q <= 1'b0;
            if (first_q) rp_q <= iRiceParam;
            case (state_q)
               S_UNARY: begin
                  if (!iBit) begin
                     if (overflow) begin
                        err_q   <= 1'b1;
                        q_q     <= '0;
                        first_q <= 1'b1;
                     end else begin
                        q_q <= q_q + 1'b1;
                     end
                  end else if (rp_eff == '0) begin
                     q_q     <= '0;
                     first_q <= 1'b1;
                  end else begin
                     state_q <= S_REM;
                     cnt_q   <= rp_eff;
                     r_q     <= '0;
                  end
               end
               S_REM: begin
                  r_q   <= r_next;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == RP_W'(1)) begin
                     state_q <= S_UNARY;
                     q_q     <= '0;
                     first_q <= 1'b1;
                  end
               end
               default: state_q <= S_UNARY;
            endcase
            if (done_unary || done_rem) begin
               sample_q <= residual;
`ifdef RICE_DEC_MSBLSB_EN
               msb_q    <= q_q;
               lsb_q    <= (state_q == S_REM) ? r_next : '0;
`endif
            end
         end
      end
   end

   assign oReady  = !err_q;
   assign oValid  = valid_q;
   assign oSample = sample_q;
   assign oError  = err_q;
`ifdef RICE_DEC_MSBLSB_EN
   assign oMSB    = msb_q;
   assign oLSB    = lsb_q;
`endif

endmodule

// File: tb/tb_variable_rice_decoder.sv
// Scoreboard bench for variable_rice_decoder: expected residuals and their
// output cycle are queued when the final bit is driven and checked on oValid.
module tb_variable_rice_decoder;

   logic               iClock = 1'b0;
   logic               iReset = 1'b0;
   logic               iValid = 1'b0;
   logic               iBit = 1'b0;
   logic        [3:0]  iRiceParam = 4'd0;
   logic               oReady;
   logic signed [15:0] oSample;
   logic               oValid;
   logic               oError;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   variable_rice_decoder #(.DATA_W(16), .RP_W(4)) dut (
      .iClock     (iClock),
      .iReset     (iReset),
      .iValid     (iValid),
      .iBit       (iBit),
      .oReady     (oReady),
      .iRiceParam (iRiceParam),
      .oSample    (oSample),
      .oValid     (oValid),
      .oError     (oError)
   );

   always #5 iClock = ~iClock;
   always @(posedge iClock) cyc <= cyc + 1;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   always @(negedge iClock) begin
      if (oValid) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sample", oSample, e.val);
            chk("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic idle(input int n);
      iValid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      iValid = 1'b0;
      iReset = 1'b1;
      tick();
      iReset = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int rp, input bit first, input int gapmax);
      repeat ($urandom_range(0, gapmax)) begin
         iValid     = 1'b0;
         iBit       = 1'($urandom);
         iRiceParam = 4'($urandom);
         tick();
      end
      iValid     = 1'b1;
      iBit       = b;
      iRiceParam = first ? 4'(rp) : 4'($urandom);
      tick();
   endtask

   // Drive one codeword; when expect_out is set, queue the residual.
   task automatic send_cw(input int rp, input int q, input int r, input int exp_val,
                          input int gapmax, input bit expect_out);
      exp_t e;
      for (int i = 0; i < q; i++) send_bit(1'b0, rp, i == 0, gapmax);
      send_bit(1'b1, rp, q == 0, gapmax);
      for (int j = rp - 1; j >= 0; j--) send_bit(1'((r >> j) & 1), rp, 1'b0, gapmax);
      if (expect_out) begin
         e.val = exp_val;
         e.cyc = cyc;
         sb.push_back(e);
      end
   endtask

   int tbl_rp[3]  = '{0, 4, 6};
   int tbl_q[3]   = '{40, 15, 0};
   int tbl_r[3]   = '{0, 5, 62};
   int tbl_exp[3] = '{20, -123, 31};

   initial begin
      int rp, q, r, u, qmax, ev;

      do_reset();
      chk("reset_oValid", oValid, 0);
      chk("reset_oSample", oSample, 0);
      chk("reset_oError", oError, 0);
      chk("reset_oReady", oReady, 1);

      for (int k = 0; k < 3; k++) begin
         send_cw(tbl_rp[k], tbl_q[k], tbl_r[k], tbl_exp[k], 0, 1'b1);
         idle(3);
      end

      for (int k = 0; k < 3; k++) send_cw(tbl_rp[k], tbl_q[k], tbl_r[k], tbl_exp[k], 0, 1'b1);
      idle(3);

      for (int k = 0; k < 3; k++) send_cw(tbl_rp[k], tbl_q[k], tbl_r[k], tbl_exp[k], 3, 1'b1);
      idle(3);

      // Largest representable code at rp=12: q=15, r=4095 -> u=65535.
      send_cw(12, 15, 4095, -32768, 0, 1'b1);
      idle(2);

      for (int k = 0; k < 10; k++) begin
         rp   = $urandom_range(0, 15);
         qmax = 65535 >> rp;
         q    = $urandom_range(0, (qmax < 5) ? qmax : 5);
         r    = (rp == 0) ? 0 : $urandom_range(0, (1 << rp) - 1);
         u    = (q << rp) | r;
         ev   = (u % 2 == 0) ? (u / 2) : -((u + 1) / 2);
         send_cw(rp, q, r, ev, 2, 1'b1);
      end
      idle(3);
      chk("queue_drained", sb.size(), 0);

      // Quotient overflow at rp=15: the second zero cannot fit.
      send_bit(1'b0, 15, 1'b1, 0);
      chk("ovf_first_zero_oError", oError, 0);
      send_bit(1'b0, 15, 1'b0, 0);
      chk("ovf_oError", oError, 1);
      chk("ovf_oReady", oReady, 0);
      chk("ovf_oValid", oValid, 0);
      send_bit(1'b1, 0, 1'b0, 0);
      send_bit(1'b1, 0, 1'b0, 0);
      chk("ovf_sticky", oError, 1);
      idle(1);
      do_reset();
      chk("ovf_reset_oError", oError, 0);
      chk("ovf_reset_oReady", oReady, 1);
      send_cw(0, 0, 0, 0, 0, 1'b1);
      idle(2);

      // Reset in the middle of the remainder field discards the codeword.
      send_bit(1'b1, 4, 1'b1, 0);
      send_bit(1'b0, 4, 1'b0, 0);
      send_bit(1'b1, 4, 1'b0, 0);
      iValid = 1'b1;
      iBit   = 1'b1;
      iReset = 1'b1;
      tick();
      iReset = 1'b0;
      iValid = 1'b0;
      chk("midrem_oValid", oValid, 0);
      idle(3);
      chk("midrem_oValid_later", oValid, 0);
      send_cw(4, 15, 5, -123, 0, 1'b1);
      idle(3);
      chk("final_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/variable_rice_decoder.md
Name: variable_rice_decoder

Overview:
- Serial Rice/FLAC residual decoder: consumes one coded bit per accepted cycle and reconstructs signed 16-bit residuals.
- Inverse of VariableRiceEncoder.
  - Unary quotient: q zeros terminated by a single 1.
  - Then `iRiceParam` remainder bits, MSB first.
  - Then zigzag decode.
- Sits between the bitstream unpacker and the LPC/fixed-predictor reconstruction stage in the decoder path.

Parameters:
- DATA_W, 16, residual and unsigned-code width.
- RP_W, 4, Rice parameter width (valid rp range 0..15).

Ports:
- iClock  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iValid  in  1  iBit is valid this cycle
- iBit  in  1  next coded bit, stream order
- oReady  out  1  decoder accepts iBit this cycle
- iRiceParam  in  RP_W  Rice parameter, sampled on the first bit of each codeword
- oSample  out  DATA_W signed  decoded residual
- oValid  out  1  one-cycle pulse, oSample valid
- oError  out  1  sticky quotient-overflow flag

Behaviour:
- Clock and reset: one clock (iClock); iReset is synchronous, active-high.
- Reset values: oSample=0, oValid=0, oError=0. State=S_UNARY, q=0, r=0, cnt=0, first=1.
- Bit acceptance: a bit is accepted when iValid && oReady.
  - oReady = !oError. No other stalls; back-to-back codewords run without bubbles.
  - No output backpressure: downstream must take oValid pulses.
  - iValid low: all state held, no progress.
- Codeword start: on the first accepted bit of a codeword (first=1), latch rp=iRiceParam and clear first. iRiceParam is ignored at all other times.
- S_UNARY:
  - Bit 0: q<=q+1.
  - Bit 1 with rp==0: codeword complete, u=q.
  - Bit 1 with rp>0: go to S_REM, cnt<=rp, r<=0.
- S_REM:
  - Each accepted bit: r<=(r<<1)|iBit, cnt<=cnt-1.
  - Bit accepted with cnt==1: complete, u=(q<<rp)|r_next. Return to S_UNARY.
- Completion:
  - Set q=0, first=1.
  - In the cycle after the final bit: oValid=1 and oSample=(u>>1) ^ -(u&1). Equivalently, even u gives u/2 and odd u gives -(u+1)/2.
  - oValid is low in every other cycle; oSample holds its last value.
- Latency: oValid is asserted exactly 1 cycle after the last bit of a codeword is accepted.
- Overflow:
  - A zero accepted in S_UNARY with q == (2^DATA_W-1)>>rp means u cannot fit.
  - Response: set oError=1 (sticky until iReset), discard the codeword, no oValid. oReady drops the next cycle.
- Arithmetic: q is a DATA_W counter. The shift q<<rp is computed at DATA_W+RP_W width; the overflow check guarantees the upper bits are zero.
- Reset mid-codeword: partial q/r discarded, no oValid, state returns to reset values on the next edge.
- Simultaneous events: iReset wins over any accepted bit.

Optional Feature:
- RICE_DEC_MSBLSB_EN.
- Defined: adds output ports oMSB [DATA_W] and oLSB [DATA_W]. They carry the completed quotient q and the remainder r, registered with oValid, so benches can cross-check field-by-field against VariableRiceEncoder oMSB/oLSB. Both reset to 0.
- Undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Shared package rice_pkg:
  - DATA_W and RP_W defaults.
  - State encoding S_UNARY=0, S_REM=1.
  - zigzag_decode function; reused by the encoder bench model.
- One natural sub-module: rice_zigzag_decode (combinational u -> signed residual). Instantiated at the output register input.
- FSM, counters and overflow check stay in the top.

Test Plan:
- rp=0: 40 zeros then 1 -> oValid one cycle later, oSample=20 (u=40).
- rp=4: 15 zeros, 1, then 0101 -> oSample=-123 (q=15, r=5, u=245).
- rp=6: 1 then 111110 -> oSample=31 (u=62).
- Stream the three codewords back-to-back with iValid held high -> exactly three oValid pulses (20, -123, 31), no bubbles. iRiceParam changes mid-codeword are ignored.
- Random iValid gaps inserted into the same stream -> identical outputs, with each oValid one cycle after its final accepted bit.
- Overflow and reset:
  - rp=15, send 0,0 -> oError=1 after the second zero, no oValid, oReady=0.
  - Then iReset for 1 cycle -> oError=0, oReady=1; a fresh rp=0 stream "1" -> oSample=0.
  - Reset asserted mid-S_REM -> no oValid.
